// File: rtl/reg_write_pkg.sv
// Shared definitions for the register write path.
// State encoding and a constant-width helper.
package reg_write_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_write_ctrl_decoder.sv
// Binary index to one-hot register strobe decoder.
// All-zero output when the enable is low.
module reg_index_decoder
  import reg_write_pkg::*;
#(
  parameter int NUM_REGS = 23
) (
  input  logic                        en,
  input  logic [clog2(NUM_REGS)-1:0]  idx,
  output logic [NUM_REGS-1:0]         onehot
);

  localparam int IDX_W = clog2(NUM_REGS);

  // One strobe bit per register, gated by the write enable
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Bus-to-register-file write controller.
// Single writes, range errors and wrapping bursts.
module reg_write_ctrl
  import reg_write_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              DATA_W    = 32,
  parameter int              NUM_REGS  = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              LEN_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic              s_burst,
  input  logic [LEN_W-1:0]  s_len,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic              s_ready,
  output logic              s_err,
  output logic [NUM_REGS-1:0] to_reg,
  output logic [DATA_W-1:0] to_data
);

  localparam int IDX_W = clog2(NUM_REGS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REGS-1:0] to_reg_q, to_reg_d;
  logic [DATA_W-1:0]   to_data_q, to_data_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   addr_off;
  logic                in_range;
  logic                accept;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    idx_inc;

  assign s_ready  = (state_q != ST_RECOVER);
  assign accept   = s_sel & s_wr & s_ready;
  assign addr_off = s_addr - BASE_ADDR;
  assign in_range = (s_addr >= BASE_ADDR) &&
                    (addr_off < ADDR_W'(NUM_REGS));

  // Bursts continue from the stored index; IDLE uses the bus address
  assign wr_idx  = (state_q == ST_IDLE) ?
                   addr_off[IDX_W-1:0] : idx_q;
  assign idx_inc = (wr_idx == IDX_W'(NUM_REGS - 1)) ?
                   '0 : wr_idx + IDX_W'(1);

  // Next-state, index/counter and error decisions
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (s_burst && (s_len != '0)) begin
              cnt_d   = s_len;
              idx_d   = idx_inc;
              state_d = ST_BURST;
            end
          end
        end
      end
      ST_BURST: begin
        if (!s_sel) begin
          err_d   = 1'b1;
          state_d = ST_RECOVER;
        end else if (s_wr) begin
          wr_en = 1'b1;
          idx_d = idx_inc;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Data copy follows the strobe; holds otherwise
  always_comb begin
    to_data_d = wr_en ? s_din : to_data_q;
  end

  reg_index_decoder #(
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .en     (wr_en),
    .idx    (wr_idx),
    .onehot (to_reg_d)
  );

  // State and registered outputs; reset also drops a pending strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      to_reg_q  <= '0;
      to_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      to_reg_q  <= to_reg_d;
      to_data_q <= to_data_d;
      err_q     <= err_d;
    end
  end

  assign to_reg  = to_reg_q;
  assign to_data = to_data_q;
  assign s_err   = err_q;

endmodule
